ddr3_lane_read_train_ctrl: RTL and testbench

Per-lane read-training sequencer that drives the IOD input delay line and eye-monitor controls of one DDR3 DQ lane. It consumes the lane's deserialised data and eye-monitor flags, sweeps the input delay tap by tap, and finds the widest passing window of a known read pattern (MPR readout). It then parks the delay at the window centre and reports the result to the DDRPHY training arbiter.

---
 rtl/ddr3_train_pkg.sv | 24 ++
 rtl/train_window_tracker.sv | 98 +++++++++
 rtl/ddr3_lane_read_train_ctrl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_ddr3_lane_read_train_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_train_pkg.sv
// Shared definitions for the DDR3 lane training controllers.
//   train_state_e : read-training sequencer states
//   MPR_PATTERN   : default word returned by an MPR readout on one lane
//   TRAIN_TAP_W   : width of the IOD delay tap counter, common to all lane controllers
package ddr3_train_pkg;

  localparam int         TRAIN_TAP_W = 7;
  localparam logic [7:0] MPR_PATTERN = 8'h55;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CLR,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_STEP,
    S_CALC,
    S_CENTER,
    S_DONE,
    S_FAIL
  } train_state_e;

endpackage

// File: rtl/train_window_tracker.sv
// Tracks the current run of passing taps and the best (widest, earliest) window.
//   fab_clk_i, reset_n_i : clock, synchronous active-low reset
//   clear_i              : wipe run and best window (start of a new training)
//   strobe_i             : one-cycle evaluation of the tap just sampled
//   pass_i               : result of that tap
//   close_i              : sweep ends at this tap; close any open run
//   cur_tap_i            : tap being evaluated
//   win_start_o          : first tap of the best window
//   win_width_o          : width of the best window (0 = none)
module train_window_tracker
  import ddr3_train_pkg::*;
#(
  parameter int TAP_W = TRAIN_TAP_W
) (
  input  logic             fab_clk_i,
  input  logic             reset_n_i,
  input  logic             clear_i,
  input  logic             strobe_i,
  input  logic             pass_i,
  input  logic             close_i,
  input  logic [TAP_W-1:0] cur_tap_i,
  output logic [TAP_W-1:0] win_start_o,
  output logic [TAP_W:0]   win_width_o
);

  localparam int           TAP_W1  = TAP_W + 1;
  localparam logic [TAP_W:0] WID_ONE = TAP_W1'(1);

  logic             run_open_q,   run_open_d;
  logic [TAP_W-1:0] run_start_q,  run_start_d;
  logic [TAP_W:0]   run_len_q,    run_len_d;
  logic [TAP_W-1:0] best_start_q, best_start_d;
  logic [TAP_W:0]   best_width_q, best_width_d;

  logic [TAP_W-1:0] cand_start;
  logic [TAP_W:0]   cand_len;
  logic             ending;

  always_comb begin
    run_open_d   = run_open_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_width_d = best_width_q;
    cand_start   = run_start_q;
    cand_len     = run_len_q;
    ending       = 1'b0;

    if (clear_i) begin
      run_open_d   = 1'b0;
      run_start_d  = '0;
      run_len_d    = '0;
      best_start_d = '0;
      best_width_d = '0;
    end else if (strobe_i) begin
      if (pass_i) begin
        if (run_open_q) begin
          cand_len = run_len_q + WID_ONE;
        end else begin
          cand_start = cur_tap_i;
          cand_len   = WID_ONE;
        end
        // a passing last tap still ends the run, including itself
        ending = close_i;
      end else begin
        ending = run_open_q;
      end
      run_start_d = cand_start;
      run_len_d   = cand_len;
      run_open_d  = pass_i && !close_i;
      // strict compare keeps the earlier window on a tie
      if (ending && (cand_len > best_width_q)) begin
        best_start_d = cand_start;
        best_width_d = cand_len;
      end
    end
  end

  always_ff @(posedge fab_clk_i) begin
    if (!reset_n_i) begin
      run_open_q   <= 1'b0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_width_q <= '0;
    end else begin
      run_open_q   <= run_open_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_width_q <= best_width_d;
    end
  end

  assign win_start_o = best_start_q;
  assign win_width_o = best_width_q;

endmodule

// File: rtl/ddr3_lane_read_train_ctrl.sv
// Read-training sequencer for one DDR3 DQ lane. Sweeps the IOD input delay
// from tap 0 upward, scores each tap against the MPR pattern and eye-monitor
// flags, then walks the delay back to the centre of the widest passing window.
//   fab_clk_i, reset_n_i         : fabric clock, synchronous active-low reset
//   train_start_i                : start pulse (accepted in IDLE/DONE/FAIL)
//   rx_valid_i, rx_data_i        : deserialised lane data and qualifier
//   eye_monitor_early/late_i     : eye-monitor flags, any assertion fails the tap
//   delay_line_out_of_range_i    : delay line saturated
//   delay_line_load/move/direction_o, eye_monitor_clear_flags_o : IOD controls
//   train_busy/done/fail_o       : status to the training arbiter
//   win_start_o, win_width_o     : best window found
//   final_tap_o                  : tap the delay line was parked at
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for train_start_i
// S_LOAD   | delay line load pulse, tap returns to 0
// S_CLR    | eye-monitor clear pulse, per-tap counters and pass flag reset
// S_SETTLE | let the delay line settle after a change
// S_SAMPLE | compare valid words and watch eye flags, bounded by timeout
// S_EVAL   | window bookkeeping, decide step or finish sweep
// S_STEP   | increment move pulse
// S_CALC   | check window width, compute centre target
// S_CENTER | decrement toward target, one pulse every second cycle
// S_DONE   | success, holding final tap
// S_FAIL   | failure, holding final tap
module ddr3_lane_read_train_ctrl
  import ddr3_train_pkg::*;
#(
  parameter int         TAP_W         = TRAIN_TAP_W,
  parameter int         MAX_TAP       = 127,
  parameter int         SETTLE_CYCLES = 8,
  parameter int         SAMPLES       = 16,
  parameter logic [7:0] EXP_PATTERN   = MPR_PATTERN,
  parameter int         MIN_WINDOW    = 4,
  parameter int         TIMEOUT       = 1024
) (
  input  logic             fab_clk_i,
  input  logic             reset_n_i,
  input  logic             train_start_i,
  input  logic             rx_valid_i,
  input  logic [7:0]       rx_data_i,
  input  logic             eye_monitor_early_i,
  input  logic             eye_monitor_late_i,
  input  logic             delay_line_out_of_range_i,
  output logic             delay_line_load_o,
  output logic             delay_line_move_o,
  output logic             delay_line_direction_o,
  output logic             eye_monitor_clear_flags_o,
  output logic             train_busy_o,
  output logic             train_done_o,
  output logic             train_fail_o,
  output logic [TAP_W-1:0] win_start_o,
  output logic [TAP_W:0]   win_width_o,
  output logic [TAP_W-1:0] final_tap_o
);

  localparam int TAP_W1 = TAP_W + 1;
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int SMP_W  = $clog2(SAMPLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_ONE   = SET_W'(1);
  localparam logic [SMP_W-1:0] SMP_LD    = SMP_W'(SAMPLES);
  localparam logic [SMP_W-1:0] SMP_ONE   = SMP_W'(1);
  localparam logic [TO_W-1:0]  TO_LD     = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
  localparam logic [TAP_W-1:0] MAX_TAP_T = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] TAP_ONE   = TAP_W'(1);
  localparam logic [TAP_W:0]   WID_ONE   = TAP_W1'(1);
  localparam logic [TAP_W:0]   MIN_WIN_T = TAP_W1'(MIN_WINDOW);

  train_state_e     state_q, state_d;
  logic             load_q, load_d;
  logic             move_q, move_d;
  logic             dir_q, dir_d;
  logic             clr_q, clr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [TAP_W-1:0] final_tap_q, final_tap_d;
  logic [TAP_W-1:0] cur_tap_q, cur_tap_d;
  logic [TAP_W-1:0] target_q, target_d;
  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [SMP_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             tap_pass_q, tap_pass_d;
  logic             phase_q, phase_d;
  logic             oor_prev_q;

  logic             win_clear, win_strobe, win_close;
  logic [TAP_W-1:0] win_start;
  logic [TAP_W:0]   win_width;
  logic [TAP_W:0]   half_w, target_sum;
  logic             oor_rise;

  train_window_tracker #(
    .TAP_W (TAP_W)
  ) u_window (
    .fab_clk_i   (fab_clk_i),
    .reset_n_i   (reset_n_i),
    .clear_i     (win_clear),
    .strobe_i    (win_strobe),
    .pass_i      (tap_pass_q),
    .close_i     (win_close),
    .cur_tap_i   (cur_tap_q),
    .win_start_o (win_start),
    .win_width_o (win_width)
  );

  // centre rounds down: start + floor((width-1)/2)
  assign half_w     = (win_width - WID_ONE) >> 1;
  assign target_sum = {1'b0, win_start} + half_w;
  assign oor_rise   = delay_line_out_of_range_i & ~oor_prev_q;

  always_comb begin
    state_d      = state_q;
    load_d       = 1'b0;
    move_d       = 1'b0;
    dir_d        = dir_q;
    clr_d        = 1'b0;
    cur_tap_d    = cur_tap_q;
    target_d     = target_q;
    settle_cnt_d = settle_cnt_q;
    smp_cnt_d    = smp_cnt_q;
    to_cnt_d     = to_cnt_q;
    tap_pass_d   = tap_pass_q;
    phase_d      = phase_q;
    final_tap_d  = final_tap_q;
    win_clear    = 1'b0;
    win_strobe   = 1'b0;
    win_close    = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (train_start_i) begin
          state_d     = S_LOAD;
          load_d      = 1'b1;
          cur_tap_d   = '0;
          final_tap_d = '0;
          win_clear   = 1'b1;
        end
      end
      S_LOAD: begin
        state_d   = S_CLR;
        clr_d     = 1'b1;
        cur_tap_d = '0;
      end
      S_CLR: begin
        state_d      = S_SETTLE;
        settle_cnt_d = SETTLE_LD;
        smp_cnt_d    = SMP_LD;
        to_cnt_d     = TO_LD;
        tap_pass_d   = 1'b1;
      end
      S_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q - SET_ONE;
        end
      end
      S_SAMPLE: begin
        if (eye_monitor_early_i || eye_monitor_late_i) begin
          tap_pass_d = 1'b0;
        end
        if (rx_valid_i) begin
          smp_cnt_d = smp_cnt_q - SMP_ONE;
          if (rx_data_i != EXP_PATTERN) begin
            tap_pass_d = 1'b0;
          end
        end
        if (rx_valid_i && (smp_cnt_q == SMP_ONE)) begin
          state_d = S_EVAL;
        end else if (to_cnt_q == '0) begin
          tap_pass_d = 1'b0;
          state_d    = S_EVAL;
        end else begin
          to_cnt_d = to_cnt_q - TO_ONE;
        end
      end
      S_EVAL: begin
        win_strobe = 1'b1;
        win_close  = (cur_tap_q == MAX_TAP_T) || delay_line_out_of_range_i;
        if (win_close) begin
          state_d = S_CALC;
        end else begin
          state_d   = S_STEP;
          move_d    = 1'b1;
          dir_d     = 1'b1;
          cur_tap_d = cur_tap_q + TAP_ONE;
        end
      end
      S_STEP: begin
        state_d = S_CLR;
        clr_d   = 1'b1;
      end
      S_CALC: begin
        phase_d = 1'b0;
        if (win_width < MIN_WIN_T) begin
          state_d     = S_FAIL;
          final_tap_d = cur_tap_q;
        end else begin
          state_d  = S_CENTER;
          target_d = target_sum[TAP_W-1:0];
        end
      end
      S_CENTER: begin
        if (oor_rise) begin
          state_d     = S_FAIL;
          final_tap_d = cur_tap_q;
        end else if (cur_tap_q == target_q) begin
          state_d     = S_DONE;
          final_tap_d = cur_tap_q;
        end else if (!phase_q) begin
          move_d    = 1'b1;
          dir_d     = 1'b0;
          cur_tap_d = cur_tap_q - TAP_ONE;
          phase_d   = 1'b1;
        end else begin
          phase_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = !(state_d inside {S_IDLE, S_DONE, S_FAIL});
    done_d = (state_d == S_DONE);
    fail_d = (state_d == S_FAIL);
  end

  always_ff @(posedge fab_clk_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      load_q       <= 1'b0;
      move_q       <= 1'b0;
      dir_q        <= 1'b0;
      clr_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      final_tap_q  <= '0;
      cur_tap_q    <= '0;
      target_q     <= '0;
      settle_cnt_q <= '0;
      smp_cnt_q    <= '0;
      to_cnt_q     <= '0;
      tap_pass_q   <= 1'b0;
      phase_q      <= 1'b0;
      oor_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_q       <= load_d;
      move_q       <= move_d;
      dir_q        <= dir_d;
      clr_q        <= clr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      final_tap_q  <= final_tap_d;
      cur_tap_q    <= cur_tap_d;
      target_q     <= target_d;
      settle_cnt_q <= settle_cnt_d;
      smp_cnt_q    <= smp_cnt_d;
      to_cnt_q     <= to_cnt_d;
      tap_pass_q   <= tap_pass_d;
      phase_q      <= phase_d;
      oor_prev_q   <= delay_line_out_of_range_i;
    end
  end

  assign delay_line_load_o         = load_q;
  assign delay_line_move_o         = move_q;
  assign delay_line_direction_o    = dir_q;
  assign eye_monitor_clear_flags_o = clr_q;
  assign train_busy_o              = busy_q;
  assign train_done_o              = done_q;
  assign train_fail_o              = fail_q;
  assign win_start_o               = win_start;
  assign win_width_o               = win_width;
  assign final_tap_o               = final_tap_q;

endmodule

// File: tb/tb_ddr3_lane_read_train_ctrl.sv
// Directed bench: a small delay-line/lane model answers the DUT's load/move
// pulses with MPR data that matches only inside configured tap windows.
module tb_ddr3_lane_read_train_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       train_start;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       eye_early;
  logic       eye_late;
  logic       oor;
  logic       dl_load, dl_move, dl_dir, eye_clr;
  logic       busy, done, fail;
  logic [6:0] win_start;
  logic [7:0] win_width;
  logic [6:0] final_tap;

  always #5 clk = ~clk;

  ddr3_lane_read_train_ctrl dut (
    .fab_clk_i                 (clk),
    .reset_n_i                 (reset_n),
    .train_start_i             (train_start),
    .rx_valid_i                (rx_valid),
    .rx_data_i                 (rx_data),
    .eye_monitor_early_i       (eye_early),
    .eye_monitor_late_i        (eye_late),
    .delay_line_out_of_range_i (oor),
    .delay_line_load_o         (dl_load),
    .delay_line_move_o         (dl_move),
    .delay_line_direction_o    (dl_dir),
    .eye_monitor_clear_flags_o (eye_clr),
    .train_busy_o              (busy),
    .train_done_o              (done),
    .train_fail_o              (fail),
    .win_start_o               (win_start),
    .win_width_o               (win_width),
    .final_tap_o               (final_tap)
  );

  int n_chk = 0;
  int n_pass = 0;

  // lane model configuration
  int lo0, hi0, lo1, hi1, oor_tap, novalid_tap, late_tap;
  // lane model state
  int mtap = 0;
  int cyc = 0;
  int cyc_in_tap = 0;
  int n_load, n_up, n_down, n_ovl;
  int load_cyc, first_step_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic cfg(input int l0, input int h0, input int l1, input int h1,
                     input int oo, input int nv, input int lt);
    lo0 = l0; hi0 = h0; lo1 = l1; hi1 = h1;
    oor_tap = oo; novalid_tap = nv; late_tap = lt;
    n_load = 0; n_up = 0; n_down = 0;
    load_cyc = 0; first_step_cyc = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    train_start = 1'b1;
    @(negedge clk);
    train_start = 1'b0;
  endtask

  task automatic run_train(input string tag);
    pulse_start();
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (done || fail) break;
    end
    chk({tag, "_finished"}, 32'(done | fail), 32'd1);
  endtask

  // delay line + lane model, evaluated away from the active edge
  initial begin
    rx_valid = 1'b0; rx_data = 8'h00; eye_early = 1'b0; eye_late = 1'b0; oor = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (32'(dl_load) + 32'(dl_move) + 32'(eye_clr) > 1) n_ovl++;
      if (dl_load) begin
        mtap = 0; n_load++; load_cyc = cyc; cyc_in_tap = 0;
      end else if (dl_move) begin
        if (dl_dir) begin
          mtap++; n_up++;
          if (n_up == 1) first_step_cyc = cyc;
        end else begin
          mtap--; n_down++;
        end
        cyc_in_tap = 0;
      end else begin
        cyc_in_tap++;
      end
      rx_data   = ((mtap >= lo0 && mtap <= hi0) || (mtap >= lo1 && mtap <= hi1)) ? 8'h55 : 8'hA5;
      rx_valid  = (mtap != novalid_tap);
      eye_early = 1'b0;
      eye_late  = (mtap == late_tap) && (cyc_in_tap == 12);
      oor       = (mtap >= oor_tap);
    end
  end

  initial begin
    n_ovl = 0;
    reset_n = 1'b0;
    train_start = 1'b0;
    cfg(-1, -2, -1, -2, 1000, -1, -1);
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({dl_load, dl_move, dl_dir, eye_clr, busy, done, fail,
                              win_start, win_width, final_tap}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // single window 20..35
    cfg(20, 35, -1, -2, 1000, -1, -1);
    run_train("t1");
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_fail", 32'(fail), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_win_start", 32'(win_start), 32'd20);
    chk("t1_win_width", 32'(win_width), 32'd16);
    chk("t1_center_pulses", n_down, 32'd100);
    chk("t1_final_tap", 32'(final_tap), 32'd27);
    chk("t1_model_tap", mtap, 32'd27);
    chk("t1_tap_period", first_step_cyc - load_cyc, 32'd27);

    // window too narrow
    cfg(5, 7, -1, -2, 1000, -1, -1);
    run_train("t3");
    chk("t3_fail", 32'(fail), 32'd1);
    chk("t3_done", 32'(done), 32'd0);
    chk("t3_win_width", 32'(win_width), 32'd3);
    chk("t3_final_tap", 32'(final_tap), 32'd127);
    chk("t3_center_pulses", n_down, 32'd0);

    // out-of-range at tap 90 ends sweep inside a passing run
    cfg(80, 127, -1, -2, 90, -1, -1);
    run_train("t4");
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_win_start", 32'(win_start), 32'd80);
    chk("t4_win_width", 32'(win_width), 32'd11);
    chk("t4_final_tap", 32'(final_tap), 32'd85);
    chk("t4_center_pulses", n_down, 32'd5);

    // tap 0 times out, tap 5 failed by a late flag
    cfg(0, 10, -1, -2, 1000, 0, 5);
    run_train("t5");
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_timeout_period", first_step_cyc - load_cyc, 32'd1035);
    chk("t5_win_start", 32'(win_start), 32'd6);
    chk("t5_win_width", 32'(win_width), 32'd5);
    chk("t5_final_tap", 32'(final_tap), 32'd8);

    // restart from DONE, then reset mid-SAMPLE at tap 14
    cfg(0, 10, -1, -2, 1000, -1, -1);
    pulse_start();
    @(negedge clk);
    chk("t6_restart_load", n_load, 32'd1);
    chk("t6_done_cleared", 32'(done), 32'd0);
    repeat (392) @(negedge clk);
    chk("t6_busy_mid", 32'(busy), 32'd1);
    chk("t6_win_mid", 32'(win_width), 32'd11);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t6_reset_outputs", 32'({dl_load, dl_move, dl_dir, eye_clr, busy, done, fail,
                                 win_start, win_width, final_tap}), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_idle_after_reset", 32'(busy), 32'd0);

    // two windows, second start while busy is ignored
    cfg(10, 13, 50, 61, 1000, -1, -1);
    pulse_start();
    repeat (100) @(negedge clk);
    pulse_start();
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (done || fail) break;
    end
    chk("t2_finished", 32'(done | fail), 32'd1);
    chk("t2_single_load", n_load, 32'd1);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_win_start", 32'(win_start), 32'd50);
    chk("t2_win_width", 32'(win_width), 32'd12);
    chk("t2_final_tap", 32'(final_tap), 32'd55);

    chk("exclusive_pulses", n_ovl, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
